// File: rtl/dpwm_duty_sequencer.sv
// Duty-word sequencer for a 6-bit DPWM: soft-start ramp, slew-limited run,
// fault shutdown and clean period-aligned disable.
module dpwm_duty_sequencer #(
  parameter int DMAX       = 52,
  parameter int SLEW       = 4,
  parameter int SS_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fault,
  input  logic       req_valid,
  input  logic [5:0] req_duty,
  output logic       req_ready,
  output logic [5:0] duty_cmd,
  output logic       pwm_en,
  output logic       period_end,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SS    = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int PCW =
    (SS_PERIODS > 7) ? $clog2(SS_PERIODS + 1) : 3;

  localparam logic [6:0]     DMAX7   = 7'(DMAX);
  localparam logic [6:0]     SLEW7   = 7'(SLEW);
  localparam logic [PCW-1:0] SS_LAST = PCW'(SS_PERIODS - 1);

  logic [5:0]     phase_q, phase_d;
  logic [1:0]     state_q, state_d;
  logic [5:0]     duty_q, duty_d;
  logic [5:0]     target_q, target_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;

  logic       active;
  logic       accept;
  logic [6:0] req7;
  logic [5:0] req_clamped;
  logic [6:0] duty7;
  logic [6:0] tgt7;
  logic [6:0] up_diff;
  logic [6:0] dn_diff;
  logic [6:0] up_step;
  logic [6:0] dn_step;
  logic [6:0] slew7;
  logic [5:0] slew_duty;

  always_comb begin
    active     = (state_q == ST_SS) || (state_q == ST_RUN);
    period_end = (phase_q == 6'd63);
    accept     = req_valid && active;

    req7        = {1'b0, req_duty};
    req_clamped = (req7 > DMAX7) ? DMAX7[5:0] : req_duty;
  end

  // Slew-limited step toward target; 7-bit so differences never wrap.
  always_comb begin
    duty7   = {1'b0, duty_q};
    tgt7    = {1'b0, target_q};
    up_diff = tgt7 - duty7;
    dn_diff = duty7 - tgt7;
    up_step = (up_diff > SLEW7) ? SLEW7 : up_diff;
    dn_step = (dn_diff > SLEW7) ? SLEW7 : dn_diff;
    slew7   = duty7;
    if (tgt7 > duty7) begin
      slew7 = duty7 + up_step;
    end else if (tgt7 < duty7) begin
      slew7 = duty7 - dn_step;
    end
    slew_duty = (slew7 > DMAX7) ? DMAX7[5:0] : slew7[5:0];
  end

  always_comb begin
    phase_d  = phase_q + 6'd1;
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = accept ? req_clamped : target_q;
    pcnt_d   = pcnt_q;

    if (fault) begin
      state_d  = ST_FAULT;
      duty_d   = '0;
      target_d = '0;
      pcnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          duty_d   = '0;
          target_d = '0;
          if (period_end && en) begin
            state_d = ST_SS;
            pcnt_d  = '0;
          end
        end
        ST_SS: begin
          if (period_end) begin
            if (!en) begin
              state_d  = ST_IDLE;
              duty_d   = '0;
              target_d = '0;
              pcnt_d   = '0;
            end else if (duty_q >= target_q) begin
              state_d = ST_RUN;
            end else if (pcnt_q == SS_LAST) begin
              duty_d = duty_q + 6'd1;
              pcnt_d = '0;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (period_end) begin
            if (!en) begin
              state_d  = ST_IDLE;
              duty_d   = '0;
              target_d = '0;
              pcnt_d   = '0;
            end else begin
              duty_d = slew_duty;
            end
          end
        end
        ST_FAULT: begin
          duty_d   = '0;
          target_d = '0;
          if (!en) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      pcnt_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign req_ready = active;
  assign pwm_en    = active;
  assign duty_cmd  = duty_q;
  assign state     = state_q;

endmodule

// File: tb/tb_dpwm_duty_sequencer.sv
// Bench for dpwm_duty_sequencer: table-driven run slew/clamp vectors,
// scoreboarded period updates and hand-written fault/disable/reset cases.
module tb_dpwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fault;
  logic       req_valid;
  logic [5:0] req_duty;
  logic       req_ready;
  logic [5:0] duty_cmd;
  logic       pwm_en;
  logic       period_end;
  logic [1:0] state;

  dpwm_duty_sequencer #(
    .DMAX(52),
    .SLEW(4),
    .SS_PERIODS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .fault(fault),
    .req_valid(req_valid),
    .req_duty(req_duty),
    .req_ready(req_ready),
    .duty_cmd(duty_cmd),
    .pwm_en(pwm_en),
    .period_end(period_end),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int    duty;
    int    st;
    string tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit v;
    int d;
    int ed;
    int es;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input int d, input int s, input string tag);
    exp_t e;
    e.duty = d;
    e.st   = s;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_duty"}, int'(duty_cmd), e.duty);
      check({e.tag, "_state"}, int'(state), e.st);
    end
  endtask

  // Returns at a negedge where period_end is high (phase 63).
  task automatic wait_pe();
    int k;
    k = 0;
    while (!period_end && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (!period_end) begin
      n_chk++;
      n_fail++;
      $display("FAIL period_end_timeout: got 0 expected 1 within 80 clk");
    end
  endtask

  // Waits through the next period_end edge; lands at phase 0.
  task automatic step_period();
    wait_pe();
    @(negedge clk);
  endtask

  task automatic send_req(input int d);
    req_valid = 1'b1;
    req_duty  = 6'(d);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic add(input bit v, input int d, input int ed, input int es);
    vec_t r;
    r.v  = v;
    r.d  = d;
    r.ed = ed;
    r.es = es;
    vt.push_back(r);
  endtask

  task automatic count_first_pe(input string name);
    int n;
    n = 0;
    while (!period_end && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    check(name, n, 63);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add(1, 30, 14, 2); add(0, 0, 18, 2); add(0, 0, 22, 2);
    add(0, 0, 26, 2);  add(0, 0, 30, 2); add(0, 0, 30, 2);
    add(1, 3, 26, 2);  add(0, 0, 22, 2); add(0, 0, 18, 2);
    add(0, 0, 14, 2);  add(0, 0, 10, 2); add(0, 0, 6, 2);
    add(0, 0, 3, 2);   add(0, 0, 3, 2);
    add(1, 63, 7, 2);  add(0, 0, 11, 2); add(0, 0, 15, 2);
    add(0, 0, 19, 2);  add(0, 0, 23, 2); add(0, 0, 27, 2);
    add(0, 0, 31, 2);  add(0, 0, 35, 2); add(0, 0, 39, 2);
    add(0, 0, 43, 2);  add(0, 0, 47, 2); add(0, 0, 51, 2);
    add(0, 0, 52, 2);  add(0, 0, 52, 2);
    add(1, 50, 50, 2); add(0, 0, 50, 2);
    add(1, 52, 52, 2); add(0, 0, 52, 2);

    rst       = 1'b1;
    en        = 1'b0;
    fault     = 1'b0;
    req_valid = 1'b0;
    req_duty  = '0;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty_cmd), 0);
    check("rst_state", int'(state), 0);
    check("rst_pwm_en", int'(pwm_en), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_period_end", int'(period_end), 0);
    rst = 1'b0;
    count_first_pe("first_period_end_clks");

    // Soft start to 10
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ss_entry_state", int'(state), 1);
    check("ss_entry_duty", int'(duty_cmd), 0);
    check("ss_entry_pwm_en", int'(pwm_en), 1);
    check("ss_entry_ready", int'(req_ready), 1);
    send_req(10);
    for (int p = 1; p <= 41; p++) begin
      sb_push((p <= 40) ? p / 4 : 10, (p <= 40) ? 1 : 2,
              $sformatf("ss_p%0d", p));
    end
    for (int p = 1; p <= 41; p++) begin
      if (p == 2) begin
        repeat (30) @(negedge clk);
        check("ss_mid_period_duty", int'(duty_cmd), 0);
      end
      step_period();
      sb_check();
    end

    // Run-mode slew and clamp vectors
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].v) send_req(vt[i].d);
      sb_push(vt[i].ed, vt[i].es, $sformatf("vec%0d", i));
      step_period();
      sb_check();
    end

    // Request on the period_end clock uses the old target
    wait_pe();
    send_req(40);
    check("simul_old_target", int'(duty_cmd), 52);
    sb_push(48, 2, "simul_1");
    sb_push(44, 2, "simul_2");
    sb_push(40, 2, "simul_3");
    repeat (3) begin
      step_period();
      sb_check();
    end

    // Disable at phase 5
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("dis_mid_duty", int'(duty_cmd), 40);
    wait_pe();
    check("dis_p63_duty", int'(duty_cmd), 40);
    check("dis_p63_state", int'(state), 2);
    @(negedge clk);
    check("dis_idle_state", int'(state), 0);
    check("dis_idle_duty", int'(duty_cmd), 0);
    check("dis_idle_pwm_en", int'(pwm_en), 0);

    // Request in IDLE is ignored; target was cleared on IDLE entry
    en = 1'b1;
    send_req(20);
    step_period();
    check("reen_ss_state", int'(state), 1);
    check("reen_ss_duty", int'(duty_cmd), 0);
    step_period();
    check("reen_run_state", int'(state), 2);
    check("reen_run_duty", int'(duty_cmd), 0);
    send_req(8);
    sb_push(4, 2, "reen_up1");
    sb_push(8, 2, "reen_up2");
    repeat (2) begin
      step_period();
      sb_check();
    end

    // Fault at phase 20
    repeat (20) @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    check("fault_state", int'(state), 3);
    check("fault_duty", int'(duty_cmd), 0);
    check("fault_pwm_en", int'(pwm_en), 0);
    check("fault_ready", int'(req_ready), 0);
    fault = 1'b0;
    repeat (100) @(negedge clk);
    check("fault_hold_en", int'(state), 3);
    en = 1'b0;
    @(negedge clk);
    check("fault_exit_idle", int'(state), 0);

    // Reset mid-ramp aborts at once
    en = 1'b1;
    step_period();
    check("rst_ramp_ss", int'(state), 1);
    send_req(40);
    repeat (4) step_period();
    check("rst_ramp_duty", int'(duty_cmd), 1);
    repeat (10) @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_duty", int'(duty_cmd), 0);
    check("async_rst_pwm_en", int'(pwm_en), 0);
    @(negedge clk);
    rst = 1'b0;
    count_first_pe("rerst_period_end_clks");
    check("rerst_state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
